// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: FSM encoding, instruction
// size and the layout of one in-flight queue entry.
package bru_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bru_state_e;

  // Entry layout, MSB first: {pc, pred_taken, pred_target}
  localparam int PRED_TAKEN_W = 1;

  function automatic int entry_w(input int pc_w);
    return pc_w + PRED_TAKEN_W + pc_w;
  endfunction

endpackage

// File: rtl/bru_fifo.sv
// In-order queue of in-flight branches. Clear wins over push and pop;
// pointers wrap naturally because DEPTH is a power of two.
module bru_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty && !clear;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks predicted branches from fetch and resolves them in order against
// execute, driving flush/redirect and the BHT update port. Optional
// resolution statistics are enabled with the BRU_STATS_EN macro.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int IDX_W = 5,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [PC_W-1:0]        push_pc,
  input  logic                   push_pred_taken,
  input  logic [PC_W-1:0]        push_pred_target,
  input  logic                   res_valid,
  input  logic                   res_taken,
  input  logic [PC_W-1:0]        res_target,
  output logic                   flush,
  output logic [PC_W-1:0]        redirect_pc,
  output logic                   upd_en,
  output logic [IDX_W-1:0]       upd_addr,
  output logic                   upd_taken,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_underflow
`ifdef BRU_STATS_EN
  ,
  output logic [15:0]            stat_resolved,
  output logic [15:0]            stat_mispred
`endif
);

  localparam int EW = entry_w(PC_W);

  bru_state_e     state, next_state;
  logic [EW-1:0]  head;
  logic [PC_W-1:0] head_pc;
  logic           head_pred_taken;
  logic [PC_W-1:0] head_pred_target;
  logic [PC_W-1:0] redirect_next;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_clear;
  logic           pop;
  logic           mispredict;
  logic           underflow_hit;
  logic           push_fire;

  assign head_pc          = head[EW-1 -: PC_W];
  assign head_pred_taken  = head[PC_W];
  assign head_pred_target = head[PC_W-1:0];
  assign push_fire        = push_valid && push_ready;
  assign redirect_next    = res_taken ? res_target
                                      : head_pc + PC_W'(INSTR_BYTES);

  bru_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_fire),
    .pop   (pop),
    .clear (fifo_clear),
    .din   ({push_pc, push_pred_taken, push_pred_target}),
    .head  (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  // FLUSH keeps the queue cleared and ignores execute for its single cycle
  always_comb begin
    next_state    = state;
    push_ready    = 1'b0;
    pop           = 1'b0;
    mispredict    = 1'b0;
    fifo_clear    = 1'b0;
    underflow_hit = 1'b0;
    case (state)
      RUN: begin
        push_ready = !fifo_full;
        if (res_valid) begin
          if (fifo_empty) begin
            underflow_hit = 1'b1;
          end else begin
            pop        = 1'b1;
            mispredict = (res_taken != head_pred_taken) ||
                         (res_taken && (res_target != head_pred_target));
          end
        end
        if (mispredict) begin
          next_state = FLUSH;
          fifo_clear = 1'b1;
        end
      end
      FLUSH: begin
        next_state = RUN;
        fifo_clear = 1'b1;
      end
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush         <= 1'b0;
      redirect_pc   <= '0;
      upd_en        <= 1'b0;
      upd_addr      <= '0;
      upd_taken     <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      flush  <= mispredict;
      upd_en <= pop;
      if (pop) begin
        upd_addr  <= head_pc[IDX_W+1:2];
        upd_taken <= res_taken;
      end
      if (mispredict) redirect_pc <= redirect_next;
      if (underflow_hit) err_underflow <= 1'b1;
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (pop && stat_resolved != 16'hFFFF) stat_resolved <= stat_resolved + 16'd1;
      if (mispredict && stat_mispred != 16'hFFFF) stat_mispred <= stat_mispred + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by
// random traffic, compared against a queue-based reference model.
module tb_branch_resolve_unit;

  localparam int PC_W  = 32;
  localparam int IDX_W = 5;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic             push_valid;
  logic             push_ready;
  logic [PC_W-1:0]  push_pc;
  logic             push_pred_taken;
  logic [PC_W-1:0]  push_pred_target;
  logic             res_valid;
  logic             res_taken;
  logic [PC_W-1:0]  res_target;
  logic             flush;
  logic [PC_W-1:0]  redirect_pc;
  logic             upd_en;
  logic [IDX_W-1:0] upd_addr;
  logic             upd_taken;
  logic [$clog2(DEPTH):0] count;
  logic             err_underflow;
`ifdef BRU_STATS_EN
  logic [15:0]      stat_resolved;
  logic [15:0]      stat_mispred;
`endif

  branch_resolve_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .push_valid       (push_valid),
    .push_ready       (push_ready),
    .push_pc          (push_pc),
    .push_pred_taken  (push_pred_taken),
    .push_pred_target (push_pred_target),
    .res_valid        (res_valid),
    .res_taken        (res_taken),
    .res_target       (res_target),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .upd_en           (upd_en),
    .upd_addr         (upd_addr),
    .upd_taken        (upd_taken),
    .count            (count),
    .err_underflow    (err_underflow)
`ifdef BRU_STATS_EN
    ,
    .stat_resolved    (stat_resolved),
    .stat_mispred     (stat_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic            pt;
    logic [PC_W-1:0] tgt;
  } ent_t;

  ent_t        mq[$];
  bit          m_flushing;
  bit          m_err;
  int unsigned m_resolved;
  int unsigned m_mispred;
  int          errors;
  int          checks;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One clock of stimulus: model the edge, then check registered outputs
  task automatic applyStimulus(input bit r, input bit pv, input logic [PC_W-1:0] ppc,
                               input bit ppt, input logic [PC_W-1:0] ptgt,
                               input bit rv, input bit rt, input logic [PC_W-1:0] rtgt);
    bit              e_upd, e_flush, mis, can_push;
    logic [PC_W-1:0] e_redir;
    logic [PC_W-1:0] h_pc;
    logic [IDX_W-1:0] e_addr;
    ent_t            h, n;
    e_upd = 0; e_flush = 0; mis = 0; e_redir = '0; e_addr = '0; h_pc = '0;
    rst = r; push_valid = pv; push_pc = ppc; push_pred_taken = ppt;
    push_pred_target = ptgt; res_valid = rv; res_taken = rt; res_target = rtgt;
    #1;
    if (!r) checkOutput("push_ready", push_ready, (!m_flushing && mq.size() < DEPTH));
    if (r) begin
      mq.delete(); m_flushing = 0; m_err = 0; m_resolved = 0; m_mispred = 0;
    end else if (m_flushing) begin
      m_flushing = 0;
    end else begin
      can_push = mq.size() < DEPTH;
      if (rv) begin
        if (mq.size() == 0) m_err = 1;
        else begin
          h = mq[0];
          h_pc = h.pc;
          mis = (rt != h.pt) || (rt && rtgt != h.tgt);
          e_upd = 1;
          e_addr = h_pc[IDX_W+1:2];
          if (m_resolved < 65535) m_resolved++;
          if (mis) begin
            e_flush = 1;
            e_redir = rt ? rtgt : h.pc + 32'd4;
            if (m_mispred < 65535) m_mispred++;
          end
        end
      end
      if (mis) begin
        mq.delete(); m_flushing = 1;
      end else begin
        if (e_upd) void'(mq.pop_front());
        if (pv && can_push) begin
          n.pc = ppc; n.pt = ppt; n.tgt = ptgt;
          mq.push_back(n);
        end
      end
    end
    @(posedge clk); #1;
    checkOutput("count", count, mq.size());
    checkOutput("flush", flush, e_flush);
    checkOutput("upd_en", upd_en, e_upd);
    checkOutput("err_underflow", err_underflow, m_err);
    if (e_upd) begin
      checkOutput("upd_addr", upd_addr, e_addr);
      checkOutput("upd_taken", upd_taken, rt);
    end
    if (e_flush) checkOutput("redirect_pc", redirect_pc, e_redir);
    if (r) begin
      checkOutput("rst_redirect", redirect_pc, 0);
      checkOutput("rst_upd_addr", upd_addr, 0);
      checkOutput("rst_upd_taken", upd_taken, 0);
    end
`ifdef BRU_STATS_EN
    checkOutput("stat_resolved", stat_resolved, m_resolved);
    checkOutput("stat_mispred", stat_mispred, m_mispred);
`endif
  endtask

  task automatic idle();
    applyStimulus(0, 0, '0, 0, '0, 0, 0, '0);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, '0, 0, '0, 0, 0, '0);
  endtask

  initial begin
    bit              pv, rv, rt, ppt;
    logic [PC_W-1:0] ppc, ptgt, rtgt;
    errors = 0; checks = 0;
    mq.delete(); m_flushing = 0; m_err = 0; m_resolved = 0; m_mispred = 0;
    rst = 1; push_valid = 0; push_pc = '0; push_pred_taken = 0;
    push_pred_target = '0; res_valid = 0; res_taken = 0; res_target = '0;
    @(posedge clk); #1;

    doReset();
    idle();
    idle();

    // Correctly predicted taken branch
    applyStimulus(0, 1, 32'h40, 1, 32'h80, 0, 0, '0);
    applyStimulus(0, 0, '0, 0, '0, 1, 1, 32'h80);
    idle();

    // Predicted not-taken, actually taken
    applyStimulus(0, 1, 32'h40, 0, 32'h0, 0, 0, '0);
    applyStimulus(0, 0, '0, 0, '0, 1, 1, 32'h100);
    applyStimulus(0, 1, 32'h44, 0, 32'h0, 0, 0, '0);
    idle();

    // Fill, then pop while full with a push pending
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, 32'h200 + 32'(i * 4), 0, '0, 0, 0, '0);
    applyStimulus(0, 1, 32'h300, 0, '0, 1, 0, '0);
    applyStimulus(0, 1, 32'h300, 0, '0, 0, 0, '0);
    doReset();

    // Mispredict with a simultaneous push; not-taken redirect
    applyStimulus(0, 1, 32'h500, 1, 32'h600, 0, 0, '0);
    applyStimulus(0, 1, 32'h504, 0, '0, 0, 0, '0);
    applyStimulus(0, 1, 32'h508, 0, '0, 1, 0, '0);
    idle();

    // Wrap-around of head.pc+4
    applyStimulus(0, 1, 32'hFFFF_FFFC, 1, 32'h10, 0, 0, '0);
    applyStimulus(0, 0, '0, 0, '0, 1, 0, '0);
    idle();

    // Underflow is sticky until reset
    applyStimulus(0, 0, '0, 0, '0, 1, 1, 32'h20);
    idle();
    applyStimulus(0, 1, 32'h700, 0, '0, 0, 0, '0);
    applyStimulus(0, 0, '0, 0, '0, 1, 0, '0);
    doReset();

    // Three resolutions, one mispredicted
    applyStimulus(0, 1, 32'h800, 1, 32'h900, 0, 0, '0);
    applyStimulus(0, 0, '0, 0, '0, 1, 1, 32'h900);
    applyStimulus(0, 1, 32'h804, 0, '0, 0, 0, '0);
    applyStimulus(0, 0, '0, 0, '0, 1, 0, '0);
    applyStimulus(0, 1, 32'h808, 0, '0, 0, 0, '0);
    applyStimulus(0, 0, '0, 0, '0, 1, 1, 32'hA00);
    idle();

    // Random traffic, with occasional mid-run resets
    for (int i = 0; i < 600; i++) begin
      pv   = ($urandom_range(0, 3) != 0);
      ppc  = {$urandom_range(0, 255), 2'b00};
      ppt  = $urandom_range(0, 1);
      ptgt = {$urandom_range(0, 3), 4'h0};
      rv   = ($urandom_range(0, 2) == 0);
      rt   = $urandom_range(0, 1);
      rtgt = {$urandom_range(0, 3), 4'h0};
      if (mq.size() > 0 && $urandom_range(0, 2) != 0) begin
        rt = mq[0].pt;
        rtgt = mq[0].tgt;
      end
      applyStimulus($urandom_range(0, 60) == 0, pv, ppc, ppt, ptgt, rv, rt, rtgt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
